// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width/sign codes, FSM state
// encoding, default memory window size and request-legality helpers.
package lsu_pkg;

    localparam int unsigned MEM_ADDR_BITS_DEFAULT = 12;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RMW_RD = 2'd2;
    localparam logic [1:0] ST_RMW_WR = 2'd3;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   funct3_i    : width/sign code of the request
//   addr_lo_i   : byte offset within the word
//   rdata_i     : full word read from memory
//   wdata_i     : store data (low byte/half used for SB/SH)
//   load_data_o : selected lane, sign- or zero-extended
//   merged_o    : rdata_i with the store lane replaced (whole wdata_i for SW)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            default: load_data_o = rdata_i;
        endcase

        merged_o = rdata_i;
        case (funct3_i)
            F3_B: begin
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
                else              merged_o[15:0]  = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-only data memory.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake (ready only in IDLE)
//   req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i : request fields
//   resp_valid_o, resp_err_o, resp_rdata_o : one-cycle completion pulse and result
//   mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_rdata_i : memory side
// SB/SH are done as read-modify-write since memory only writes whole words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS = MEM_ADDR_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [31:0] merged_q, merged_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        range_err;
    logic        req_err;

    lsu_lane_align u_lane_align (
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .rdata_i     (mem_rdata_i),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    assign range_err = (req_addr_i >> MEM_ADDR_BITS) != 32'd0;
    assign req_err   = range_err || !funct3_legal(req_is_store_i, req_funct3_i) ||
                       misaligned(req_funct3_i, req_addr_i[1:0]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        merged_d     = merged_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d     = req_addr_i;
                    wdata_d    = req_wdata_i;
                    funct3_d   = req_funct3_i;
                    is_store_d = req_is_store_i;
                    if (req_err) begin
                        // Rejected: answer next cycle without touching memory.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rdata_d      = 32'd0;
                    end else if (req_is_store_i && req_funct3_i != F3_W) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                rdata_d      = is_store_q ? 32'd0 : load_data;
            end
            ST_RMW_RD: begin
                merged_d = merged_word;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                rdata_d      = 32'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            funct3_q     <= 3'd0;
            is_store_q   <= 1'b0;
            merged_q     <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            merged_q     <= merged_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory strobes decode from state only, so reset drops them asynchronously.
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        case (state_q)
            ST_ACCESS: begin
                mem_addr_o = {addr_q[31:2], 2'b00};
                if (is_store_q) begin
                    mem_write_o = 1'b1;
                    mem_wdata_o = wdata_q;
                end else begin
                    mem_read_o = 1'b1;
                end
            end
            ST_RMW_RD: begin
                mem_addr_o = {addr_q[31:2], 2'b00};
                mem_read_o = 1'b1;
            end
            ST_RMW_WR: begin
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_write_o = 1'b1;
                mem_wdata_o = merged_q;
            end
            default: ;
        endcase
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_is_store_i (req_is_store),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_err_o     (resp_err),
        .resp_rdata_o   (resp_rdata),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory model: combinational read, write on rising edge.
    logic [31:0] mem [0:1023];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            mem[10'h040] <= 32'h8899AABB;
            mem[10'h041] <= 32'h11223344;
        end else if (mem_write) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[11:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called and returns at a falling edge. lat counts cycles after the accept edge.
    task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int reads, output int writes, output logic [31:0] wword);
        bit done;
        lat = 99; err = 1'bx; rdata = 'x; reads = 0; writes = 0; wword = 32'd0;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
            reads  += int'(mem_read);
            writes += int'(mem_write);
            if (mem_write) wword = mem_wdata;
            if (resp_valid) begin
                lat = cyc; err = resp_err; rdata = resp_rdata; done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          reads;
        int          writes;
        logic [31:0] wword;
    } vec_t;

    vec_t vecs[$];

    initial begin : main
        int          lat, rd, wr;
        logic        err;
        logic [31:0] rdata, ww;
        int          seen_v, seen_w;
        string       nm;

        rst_n = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;

        //           st  f3      addr          wdata         lat err rdata        rd wr wword
        vecs.push_back('{1'b0, 3'b000, 32'h101, 32'h0, 2, 1'b0, 32'hFFFFFFAA, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h101, 32'h0, 2, 1'b0, 32'h000000AA, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h102, 32'h0, 2, 1'b0, 32'h00008899, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h102, 32'h0, 2, 1'b0, 32'hFFFF8899, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'h8899AABB, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h102, 32'hABCDEF55, 3, 1'b0, 32'h0, 1, 1, 32'h8855AABB});
        vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'h8855AABB, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h102, 32'h0, 2, 1'b0, 32'h00000055, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h100, 32'h0, 2, 1'b0, 32'hFFFFAABB, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h106, 32'h1234BEEF, 3, 1'b0, 32'h0, 1, 1, 32'hBEEF3344});
        vecs.push_back('{1'b0, 3'b010, 32'h104, 32'h0, 2, 1'b0, 32'hBEEF3344, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h104, 32'h0, 2, 1'b0, 32'h00000044, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'hFFC, 32'h12345678, 2, 1'b0, 32'h0, 0, 1, 32'h12345678});
        vecs.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0, 2, 1'b0, 32'h12345678, 1, 0, 32'h0});
        // Rejected requests: answer at accept+1, no memory traffic, rdata cleared.
        vecs.push_back('{1'b0, 3'b010, 32'h102, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h0FF, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h80000100, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b1, 3'b100, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h103, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h101, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0});

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst ready",  {31'd0, req_ready},  32'd1);
        chk("rst rvalid", {31'd0, resp_valid}, 32'd0);
        chk("rst rerr",   {31'd0, resp_err},   32'd0);
        chk("rst rdata",  resp_rdata,          32'd0);
        chk("rst mread",  {31'd0, mem_read},   32'd0);
        chk("rst mwrite", {31'd0, mem_write},  32'd0);
        chk("rst maddr",  mem_addr,            32'd0);
        chk("rst mwdata", mem_wdata,           32'd0);
        preload = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            do_req(nm, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   lat, err, rdata, rd, wr, ww);
            chk({nm, " lat"},    lat,            vecs[i].lat);
            chk({nm, " err"},    {31'd0, err},   {31'd0, vecs[i].err});
            chk({nm, " rdata"},  rdata,          vecs[i].rdata);
            chk({nm, " reads"},  rd,             vecs[i].reads);
            chk({nm, " writes"}, wr,             vecs[i].writes);
            if (vecs[i].writes != 0) chk({nm, " wword"}, ww, vecs[i].wword);
            @(negedge clk);
        end

        // Back-to-back: LW presented in the SW response cycle
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h200; req_wdata = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("b2b sw c1 rvalid", {31'd0, resp_valid}, 32'd0);
        chk("b2b sw c1 mwrite", {31'd0, mem_write},  32'd1);
        @(negedge clk);
        chk("b2b sw resp", {31'd0, resp_valid}, 32'd1);
        chk("b2b sw ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h200; req_wdata = 32'h0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("b2b lw c1 rvalid", {31'd0, resp_valid}, 32'd0);
        chk("b2b lw c1 ready",  {31'd0, req_ready},  32'd0);
        @(negedge clk);
        chk("b2b lw resp",  {31'd0, resp_valid}, 32'd1);
        chk("b2b lw rdata", resp_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Reset during RMW_RD of SB to 0x104
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h104; req_wdata = 32'h77;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("mid rmw_rd mread", {31'd0, mem_read}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst mread",  {31'd0, mem_read},   32'd0);
        chk("mid rst mwrite", {31'd0, mem_write},  32'd0);
        chk("mid rst maddr",  mem_addr,            32'd0);
        chk("mid rst mwdata", mem_wdata,           32'd0);
        chk("mid rst rvalid", {31'd0, resp_valid}, 32'd0);
        chk("mid rst ready",  {31'd0, req_ready},  32'd1);
        seen_v = 0; seen_w = 0;
        repeat (3) begin
            @(negedge clk);
            seen_v += int'(resp_valid);
            seen_w += int'(mem_write);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            seen_v += int'(resp_valid);
            seen_w += int'(mem_write);
        end
        chk("mid rst no resp",  seen_v, 0);
        chk("mid rst no write", seen_w, 0);
        do_req("post rst lw", 1'b0, 3'b010, 32'h104, 32'h0, lat, err, rdata, rd, wr, ww);
        chk("post rst lat",   lat,          2);
        chk("post rst err",   {31'd0, err}, 32'd0);
        chk("post rst rdata", rdata,        32'hBEEF3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data_memory interface.
- Sits in the MEM stage and turns pipeline load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-only memory transactions.
- Byte/halfword stores use a read-modify-write, because the memory writes full words only. Loads are lane-extracted and sign/zero-extended.
- Misaligned, out-of-range and illegal requests are flagged instead of issued.

Parameters:
MEM_ADDR_BITS, 12, byte-address bits backed by memory (4KB); any set bit in addr[31:MEM_ADDR_BITS] is a range error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept (high only in IDLE)
req_is_store  input  1  1=store, 0=load
req_funct3  input  3  RISC-V width/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid: request rejected, no memory access
resp_rdata  output  32  extended load result (0 for stores/errors)
mem_read  output  1  to data_memory MemRead
mem_write  output  1  to data_memory MemWrite
mem_addr  output  32  word-aligned address, bits [1:0]=0
mem_wdata  output  32  to data_memory write_data
mem_rdata  input  32  from data_memory read_data (combinational, same cycle)

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0. Internal captured request registers are cleared.
- States: IDLE, ACCESS, RMW_RD, RMW_WR.
- mem_* outputs are decoded from state plus captured registers. They are 0 in IDLE.
- Accept: req_valid && req_ready at a rising edge. addr/wdata/funct3/is_store are captured.
- Legal funct3:
  - loads: 000 B, 001 H, 010 W, 100 BU, 101 HU
  - stores: 000, 001, 010
  - anything else is illegal.
- Errors (illegal, misaligned, range) are checked at accept:
  - misaligned H: addr[0]=1
  - misaligned W: addr[1:0]!=0
  - range: addr[31:MEM_ADDR_BITS]!=0
  - on error: stay IDLE. Next cycle resp_valid=1, resp_err=1, resp_rdata=0. No mem_read/mem_write ever asserted.
- Legal load or SW: IDLE→ACCESS for exactly one cycle.
  - ACCESS: mem_read=1 for loads, mem_write=1 with mem_wdata=wdata for SW.
  - Edge leaving ACCESS: load result registered; next state IDLE.
  - Response: resp_valid=1, resp_err=0 in the following cycle. Latency is 2 cycles from accept edge to resp_valid cycle.
- SB/SH: IDLE→RMW_RD (mem_read=1) →RMW_WR (mem_write=1, merged word) →IDLE. resp_valid appears 3 cycles after accept.
  - Merge: lane k=addr[1:0] replaces bits [8k+7:8k] with wdata[7:0].
  - SH uses k∈{0,2} and replaces 16 bits with wdata[15:0].
  - The merged word is registered at the RMW_RD→RMW_WR edge.
- Load extraction (little-endian):
  - B/BU select byte addr[1:0]; H/HU select half addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- resp_valid pulses in the same cycle as IDLE with req_ready=1. A new request may be accepted that cycle (back-to-back, no bubble).
- resp_rdata holds its value until the next response. Store responses set it to 0.
- req_* inputs are ignored outside IDLE. Upstream must hold req_valid until accepted.
- Reset mid-operation:
  - mem_write drops asynchronously with rst_n.
  - A pending RMW that has not reached its RMW_WR edge leaves memory unmodified.
  - No resp_valid is emitted for the aborted request.

Decomposition:
- Shared package (lsu_pkg): funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, MEM_ADDR_BITS default.
- One natural sub-module: lsu_lane_align. It is purely combinational and does load extraction/extension and store-lane merge. The FSM and registers stay in load_store_unit.

Test Plan:
- Preload mem word@0x100=0x8899AABB; LB addr 0x101 → resp at accept+2, rdata=0xFFFFFFAA, err=0. LBU 0x101 → 0x000000AA. LHU 0x102 → 0x00008899.
- SB addr 0x102, wdata=0x55 over 0x8899AABB → one mem_read then one mem_write of 0x8855AABB. resp at accept+3. Subsequent LW 0x100 returns 0x8855AABB.
- LW addr 0x102 and SH addr 0x0FF → resp_valid+resp_err at accept+1, rdata=0, mem_read/mem_write never high. Same for addr 0x1000 (range) and funct3=011 (illegal).
- Back-to-back: SW 0x200=0xDEADBEEF, LW 0x200 presented in the SW resp cycle → accepted that cycle, second resp 2 cycles later, rdata=0xDEADBEEF.
- Assert rst_n=0 during RMW_RD of SB to 0x104 → all outputs 0 immediately, no resp_valid, word@0x104 unchanged after release.
- Reset values: hold rst_n=0 → req_ready=1, all other outputs 0. First request after release completes normally.
